// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter.
// Holds the controller state encoding and the expiry-counter width.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    TMO
  } arb_state_e;

  localparam int TMO_CNT_W = 8;

endpackage : wb_arb_pkg

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin selector: first requester scanning upward
// from (last+1) mod N with wrap-around.
module wb_arb_rr_pick #(
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  reqs,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    cand   = '0;
    // Scan farthest-first so the nearest requester overwrites and wins.
    for (int off = N; off >= 1; off--) begin
      cand = IW'((int'(last) + off) % N);
      if (reqs[cand]) begin
        valid        = 1'b1;
        onehot       = '0;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule : wb_arb_rr_pick

// File: rtl/wb_arb_ctrl.sv
// Wishbone bus arbiter: round-robin grant, owner-held ownership, and a
// response watchdog that forces release with a one-cycle error pulse.
module wb_arb_ctrl
  import wb_arb_pkg::*;
#(
  parameter  int NUM_MASTERS = 8,
  parameter  int TIMEOUT     = 255,
  localparam int IW          = $clog2(NUM_MASTERS),
  localparam int WDW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] m_cyc,
  input  logic                   s_ack,
  input  logic                   s_err,
  input  logic                   s_rty,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IW-1:0]          gnt_idx,
  output logic                   busy,
  output logic                   tmo_err,
  output logic [TMO_CNT_W-1:0]   tmo_cnt
);

  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

  arb_state_e             state;
  logic [WDW-1:0]         wdog;
  logic                   armed;
  logic                   pick_valid;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IW-1:0]          pick_idx;
  logic                   responded;
  logic                   owner_req;
  logic                   expire;

  wb_arb_rr_pick #(
    .N (NUM_MASTERS)
  ) u_pick (
    .reqs   (m_cyc),
    .last   (gnt_idx),
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign responded = s_ack | s_err | s_rty;
  assign owner_req = m_cyc[gnt_idx];
  assign expire    = (TIMEOUT != 0) && (wdog == WD_LIMIT);

  // NOTE: all registers update with <= so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_idx <= IW'(NUM_MASTERS - 1);
      busy    <= 1'b0;
      tmo_err <= 1'b0;
      tmo_cnt <= '0;
      wdog    <= '0;
      armed   <= 1'b0;
    end else begin
      // armed holds off granting on the first edge after reset release.
      armed   <= 1'b1;
      tmo_err <= 1'b0;
      case (state)
        IDLE: begin
          if (armed && pick_valid) begin
            gnt     <= pick_onehot;
            gnt_idx <= pick_idx;
            busy    <= 1'b1;
            wdog    <= '0;
            state   <= OWN;
          end
        end
        OWN: begin
          // Owner release beats expiry; a response beats expiry.
          if (!owner_req) begin
            gnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (responded) begin
            wdog <= '0;
          end else if (expire) begin
            tmo_err <= 1'b1;
            state   <= TMO;
            if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TMO_CNT_W'(1);
          end else if (wdog != '1) begin
            wdog <= wdog + WDW'(1);
          end
        end
        TMO: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : wb_arb_ctrl

// File: tb/tb_wb_arb_ctrl.sv
// Self-checking bench for wb_arb_ctrl (4 masters, timeout 16): directed
// scenarios with literal expectations plus randomized traffic vs a model.
module tb_wb_arb_ctrl;

  localparam int N  = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] m_cyc;
  logic         s_ack, s_err, s_rty;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic         busy, tmo_err;
  logic [7:0]   tmo_cnt;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: who owns the bus, who owned it last, how many silent
  // cycles the owner has accumulated, and whether an expiry pulse is showing.
  int md_owner, md_last, md_silent, md_cnt;
  bit md_pulse, md_armed;

  always #5 clk = ~clk;

  wb_arb_ctrl #(
    .NUM_MASTERS (N),
    .TIMEOUT     (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_cyc   (m_cyc),
    .s_ack   (s_ack),
    .s_err   (s_err),
    .s_rty   (s_rty),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .tmo_err (tmo_err),
    .tmo_cnt (tmo_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    md_owner  = -1;
    md_last   = N - 1;
    md_silent = 0;
    md_cnt    = 0;
    md_pulse  = 1'b0;
    md_armed  = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_next();
    bit rsp;
    int c;
    rsp = s_ack | s_err | s_rty;
    if (md_pulse) begin
      md_pulse = 1'b0;
      md_owner = -1;
    end else if (md_owner < 0) begin
      if (md_armed && m_cyc != 0) begin
        for (int k = 1; k <= N; k++) begin
          c = (md_last + k) % N;
          if (m_cyc[c]) begin
            md_owner  = c;
            md_last   = c;
            md_silent = 0;
            break;
          end
        end
      end
    end else if (!m_cyc[md_owner]) begin
      md_owner = -1;
    end else if (rsp) begin
      md_silent = 0;
    end else if (md_silent == TO) begin
      md_pulse = 1'b1;
      if (md_cnt < 255) md_cnt++;
    end else begin
      md_silent++;
    end
    md_armed = 1'b1;
  endtask

  task automatic compare_all();
    check("gnt", 32'(gnt), (md_owner >= 0) ? (32'd1 << md_owner) : 32'd0);
    check("gnt_idx", 32'(gnt_idx), 32'(md_last));
    check("busy", 32'(busy), 32'(md_owner >= 0));
    check("tmo_err", 32'(tmo_err), 32'(md_pulse));
    check("tmo_cnt", 32'(tmo_cnt), 32'(md_cnt));
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic step_until_busy(input int bound);
    int i = 0;
    while (!busy && i < bound) begin
      step();
      i++;
    end
    check("wait_grant", 32'(busy), 32'd1);
  endtask

  task automatic step_until_tmo(input int bound);
    int i = 0;
    do begin
      step();
      i++;
    end while (!tmo_err && i < bound);
    check("wait_tmo", 32'(tmo_err), 32'd1);
  endtask

  // Called just after a rising edge; asserts rst mid-cycle and releases it
  // just after the following edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_gnt_async", 32'(gnt), 32'd0);
    check("rst_busy_async", 32'(busy), 32'd0);
    check("rst_tmo_err", 32'(tmo_err), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_gnt_idx", 32'(gnt_idx), 32'(N - 1));
    check("rst_tmo_cnt", 32'(tmo_cnt), 32'd0);
    check("rst_tmo_err_held", 32'(tmo_err), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    m_cyc = '0;
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Round-robin rotation with all masters requesting and acking.
    m_cyc = 4'b1111;
    s_ack = 1'b1;
    do_reset();
    step();
    check("no_grant_first_edge", 32'(busy), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step_until_busy(4);
      check("rr_order_idx", 32'(gnt_idx), 32'(k % 4));
      check("rr_order_gnt", 32'(gnt), 32'd1 << (k % 4));
      step();
      step();
      m_cyc = ~(4'b0001 << (k % 4));
      step();
      check("turnaround_gap", 32'(gnt), 32'd0);
      m_cyc = 4'b1111;
    end

    // After master 1, the scan starts at 2 and skips master 0.
    m_cyc = 4'b0010;
    do_reset();
    step_until_busy(4);
    check("owner_is_1", 32'(gnt_idx), 32'd1);
    m_cyc = 4'b0101;
    step();
    check("release_to_idle", 32'(gnt), 32'd0);
    step();
    check("rr_skips_master0", 32'(gnt), 32'b0100);
    m_cyc = 4'b0000;
    step();
    step();

    // Watchdog expiry with no responses at all.
    s_ack = 1'b0;
    m_cyc = 4'b0001;
    do_reset();
    step_until_busy(4);
    repeat (16) step();
    check("no_tmo_cycle17", 32'(tmo_err), 32'd0);
    step();
    check("tmo_pulse_cycle18", 32'(tmo_err), 32'd1);
    check("gnt_held_in_tmo", 32'(gnt), 32'b0001);
    step();
    check("gnt_drop_after_tmo", 32'(gnt), 32'd0);
    check("tmo_cnt_one", 32'(tmo_cnt), 32'd1);

    // An ack on cycle 16 restarts the silent count.
    step_until_busy(4);
    repeat (15) step();
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    repeat (16) step();
    check("no_tmo_after_ack", 32'(tmo_err), 32'd0);
    step();
    check("tmo_after_17_silent", 32'(tmo_err), 32'd1);
    check("tmo_cnt_two", 32'(tmo_cnt), 32'd2);
    m_cyc = 4'b0000;
    step();
    step();

    // Reset in the middle of master 1's ownership.
    m_cyc = 4'b0010;
    do_reset();
    step_until_busy(4);
    check("owner_before_rst", 32'(gnt), 32'b0010);
    do_reset();
    m_cyc = 4'b0000;
    step();

    // Drive the expiry counter well past saturation.
    m_cyc = 4'b0001;
    for (int t = 0; t < 300; t++) step_until_tmo(40);
    check("tmo_cnt_saturated", 32'(tmo_cnt), 32'd255);
    m_cyc = 4'b0000;
    step();
    step();

    // Randomized traffic with occasional responses and rare resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 19) == 0) m_cyc = N'($urandom);
      s_ack = ($urandom_range(0, 24) == 0);
      s_err = ($urandom_range(0, 59) == 0);
      s_rty = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_wb_arb_ctrl
